// File: rtl/turret_pkg.sv
// Shared types and widths for the turret zone sequencer and its accumulator bank.
package turret_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        EVAL,
        HOLD
    } zone_state_t;

    localparam int ZONE_CNT_W = 8;
    localparam int ZONE_IDX_W = 4;

    localparam logic [ZONE_CNT_W-1:0] ZONE_CNT_MAX = '1;

endpackage

// File: rtl/zone_accum_bank.sv
// Bank of per-zone saturating hit counters with an index-selected read port
// used by the sequential threshold/argmax scan.
module zone_accum_bank
    import turret_pkg::*;
#(
    parameter int NCH = 9
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic [NCH-1:0]        i_data,
    input  logic [ZONE_IDX_W-1:0] i_idx,
    output logic [ZONE_CNT_W-1:0] o_cnt
);

    localparam logic [ZONE_CNT_W-1:0] CNT_ONE = ZONE_CNT_W'(1);

    logic [ZONE_CNT_W-1:0] r_acc [NCH];

    // Counters stick at full scale rather than wrapping to a small value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NCH; i++) begin
                r_acc[i] <= '0;
            end
        end else if (i_clr) begin
            for (int i = 0; i < NCH; i++) begin
                r_acc[i] <= '0;
            end
        end else if (i_en) begin
            for (int i = 0; i < NCH; i++) begin
                if (i_data[i] && (r_acc[i] != ZONE_CNT_MAX)) begin
                    r_acc[i] <= r_acc[i] + CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            if (i_idx == ZONE_IDX_W'(i)) begin
                o_cnt = r_acc[i];
            end
        end
    end

endmodule

// File: rtl/turret_zone_sequencer.sv
// Window sequencer: trigger, accumulate zone activity, scan for the strongest
// zone above threshold, and hand the result over a valid/ready handshake.
module turret_zone_sequencer
    import turret_pkg::*;
#(
    parameter int NCH    = 9,
    parameter int WINDOW = 90,
    parameter int THRESH = 20,
    parameter int PERIOD = 1000
) (
    input  logic                  i_fclk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_auto_en,
    input  logic [NCH-1:0]        i_data,
    input  logic                  i_target_ready,
    output logic [NCH-1:0]        o_hit,
    output logic [ZONE_IDX_W-1:0] o_target_idx,
    output logic                  o_target_valid,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int PCW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    zone_state_t r_state;
    zone_state_t w_nextState;

    logic [PCW-1:0]        r_periodCnt;
    logic [ZONE_CNT_W-1:0] r_winCnt;
    logic [ZONE_IDX_W-1:0] r_scanIdx;
    logic [ZONE_CNT_W-1:0] r_bestCnt;
    logic [ZONE_IDX_W-1:0] r_bestIdx;
    logic                  r_anyHit;
    logic [NCH-1:0]        r_hitNext;
    logic [NCH-1:0]        r_hit;
    logic [ZONE_IDX_W-1:0] r_targetIdx;
    logic                  r_done;

    logic [ZONE_CNT_W-1:0] w_zoneCnt;
    logic                  w_autoFire;
    logic                  w_lastAccum;
    logic                  w_lastScan;
    logic                  w_zoneHit;
    logic                  w_takeBest;
    logic                  w_anyFinal;
    logic [ZONE_IDX_W-1:0] w_bestIdxFinal;
    logic [NCH-1:0]        w_hitFinal;

    zone_accum_bank #(
        .NCH (NCH)
    ) u_bank (
        .i_clk  (i_fclk),
        .i_rst  (i_reset),
        .i_clr  (r_state == CLEAR),
        .i_en   (r_state == ACCUM),
        .i_data (i_data),
        .i_idx  (r_scanIdx),
        .o_cnt  (w_zoneCnt)
    );

    assign w_autoFire  = i_auto_en && (r_periodCnt == PCW'(PERIOD - 1));
    assign w_lastAccum = (r_winCnt == ZONE_CNT_W'(WINDOW - 1));
    assign w_lastScan  = (r_scanIdx == ZONE_IDX_W'(NCH - 1));

    // Strictly-greater replacement keeps the lower index on ties.
    assign w_zoneHit      = (w_zoneCnt > ZONE_CNT_W'(THRESH));
    assign w_takeBest     = w_zoneHit && (!r_anyHit || (w_zoneCnt > r_bestCnt));
    assign w_anyFinal     = r_anyHit || w_zoneHit;
    assign w_bestIdxFinal = w_takeBest ? r_scanIdx : r_bestIdx;

    always_comb begin
        w_hitFinal = r_hitNext;
        for (int i = 0; i < NCH; i++) begin
            if (r_scanIdx == ZONE_IDX_W'(i)) begin
                w_hitFinal[i] = w_zoneHit;
            end
        end
    end

    always_ff @(posedge i_fclk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (i_start || w_autoFire) w_nextState = CLEAR;
            CLEAR:   w_nextState = ACCUM;
            ACCUM:   if (w_lastAccum) w_nextState = EVAL;
            EVAL:    if (w_lastScan) w_nextState = w_anyFinal ? HOLD : IDLE;
            HOLD:    if (i_target_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        o_busy         = (r_state != IDLE);
        o_target_valid = (r_state == HOLD);
    end

    // The period counter only runs while sitting in IDLE with auto mode on.
    always_ff @(posedge i_fclk or posedge i_reset) begin
        if (i_reset) begin
            r_periodCnt <= '0;
        end else if ((r_state == IDLE) && i_auto_en && (w_nextState == IDLE)) begin
            r_periodCnt <= r_periodCnt + PCW'(1);
        end else begin
            r_periodCnt <= '0;
        end
    end

    always_ff @(posedge i_fclk or posedge i_reset) begin
        if (i_reset) begin
            r_winCnt  <= '0;
            r_scanIdx <= '0;
            r_bestCnt <= '0;
            r_bestIdx <= '0;
            r_anyHit  <= 1'b0;
            r_hitNext <= '0;
        end else if (r_state == CLEAR) begin
            r_winCnt  <= '0;
            r_scanIdx <= '0;
            r_bestCnt <= '0;
            r_bestIdx <= '0;
            r_anyHit  <= 1'b0;
            r_hitNext <= '0;
        end else if (r_state == ACCUM) begin
            r_winCnt <= r_winCnt + ZONE_CNT_W'(1);
        end else if (r_state == EVAL) begin
            r_scanIdx <= r_scanIdx + ZONE_IDX_W'(1);
            r_hitNext <= w_hitFinal;
            r_anyHit  <= w_anyFinal;
            if (w_takeBest) begin
                r_bestCnt <= w_zoneCnt;
                r_bestIdx <= r_scanIdx;
            end
        end
    end

    // Published results change only when a scan completes.
    always_ff @(posedge i_fclk or posedge i_reset) begin
        if (i_reset) begin
            r_hit       <= '0;
            r_targetIdx <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == EVAL) && w_lastScan;
            if ((r_state == EVAL) && w_lastScan) begin
                r_hit <= w_hitFinal;
                if (w_anyFinal) begin
                    r_targetIdx <= w_bestIdxFinal;
                end
            end
        end
    end

    assign o_hit        = r_hit;
    assign o_target_idx = r_targetIdx;
    assign o_done       = r_done;

endmodule

// File: doc/turret_zone_sequencer.md
# turret_zone_sequencer

Controller that sequences the 9-zone sensor accumulation window for the turret aiming path. It starts a window on a manual trigger (debounced button rising edge) or on a free-running period, and accumulates the 9-bit zone sample vector over a fixed number of cycles. It then thresholds each zone and scans for the strongest hit zone. The result goes to the turret/VGA overlay logic over a valid/ready handshake.

## Interface
- `NCH`, 9: number of zones (width of `data`, `hit`).
- `WINDOW`, 90: accumulate cycles per window; legal range 1..255.
- `THRESH`, 20: a zone is a hit when its count is strictly greater than `THRESH`.
- `PERIOD`, 1000: idle cycles between auto-triggered windows; must be ≥ 1.
- `fclk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: single-cycle trigger pulse, e.g. a button rising edge.
- `auto_en`, in, 1: enables the periodic trigger.
- `data`, in, NCH: per-zone sample; 1 = zone active this cycle.
- `target_ready`, in, 1: consumer accepts the target.
- `hit`, out, NCH: per-zone threshold result of the last completed window.
- `target_idx`, out, 4: zone index of the strongest hit.
- `target_valid`, out, 1: `target_idx` is valid and held.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at the end of each evaluation.

## Operation
- States: IDLE, CLEAR, ACCUM, EVAL, HOLD.
- **IDLE**
  - Go to CLEAR when `start`=1, or when `auto_en`=1 and the period counter is at PERIOD-1.
  - The period counter increments only in IDLE while `auto_en`=1. It clears on leaving IDLE and whenever `auto_en`=0.
  - If `start` and the auto trigger occur in the same cycle, one window starts.
- **CLEAR**: one cycle. Zero all accumulators and the window counter.
- **ACCUM**: exactly WINDOW cycles.
  - Each cycle: `acc[i] <= acc[i] + data[i]`.
  - Accumulators are 8 bits and saturate at 255.
- **EVAL**: NCH cycles, scanning zone i = 0..NCH-1, one zone per cycle.
  - Latch `hit_next[i] = acc[i] > THRESH`.
  - Track the best hit: a strictly greater count replaces it, so ties keep the lower index.
  - On the last scan cycle, update `hit` and pulse `done`.
  - If any zone hit, go to HOLD with `target_idx` = best zone. Otherwise go to IDLE; `target_valid` stays 0.
- **HOLD**
  - `target_valid`=1; `target_idx` and `hit` stay stable.
  - Go to IDLE on the cycle `target_valid && target_ready`.
- `start` pulses while `busy`=1 are dropped, not queued.
- `hit` keeps its value until the next EVAL completes.

## Timing
- Reset values: `hit`=0, `target_idx`=0, `target_valid`=0, `busy`=0, `done`=0. State is IDLE; accumulators and counters are 0.
- Reset is asynchronous. Asserting it mid-window aborts immediately, with no partial result.
- With `start` high in cycle 0 (IDLE):
  - CLEAR in cycle 1.
  - ACCUM in cycles 2..WINDOW+1; `data` is sampled in each of these cycles.
  - EVAL in cycles WINDOW+2..WINDOW+NCH+1.
- `done` and the `hit` update take effect in the cycle after the last EVAL cycle. That is cycle WINDOW+NCH+2 (101 with defaults), which is also the first HOLD or IDLE cycle.
- `target_valid` rises in cycle WINDOW+NCH+2.
- If `target_ready` is already high, HOLD lasts one cycle; IDLE follows in the next cycle.
- Auto mode: the next window's CLEAR comes exactly PERIOD cycles after re-entering IDLE.
- `target_ready` is ignored outside HOLD.

## Structure
- Package `turret_pkg`:
  - `zone_state_t` enum (IDLE, CLEAR, ACCUM, EVAL, HOLD).
  - `ZONE_CNT_W`=8.
  - `ZONE_IDX_W`=4.
- Sub-module `zone_accum_bank`: NCH saturating 8-bit counters with `clr`/`en` inputs and a read mux by index for the EVAL scan.
- The FSM, window counter, period counter and argmax tracking live in the top level.

## Test plan
1. `data`=9'h001 held high, `start` pulse, defaults → at cycle 101 `hit`=9'h001, `target_idx`=0, `target_valid`=1, `done` pulse.
2. Zone 3 active 30 cycles and zone 7 active 50 cycles; then zone 3 active 50 and zone 7 active 50 → first window `target_idx`=7; tie window `target_idx`=3; `hit`=9'h088 in both.
3. Zone 5 active exactly 20 cycles, zone 6 active 21 → `hit`=9'h040, `target_idx`=6 (threshold is strict >).
4. `data`=0, `start` pulse → `done` pulse at cycle 101, `hit`=0, `target_valid` never rises, back in IDLE at 101.
5. `target_ready`=0 for 10 cycles after valid, then 1 → `target_idx` stable throughout; IDLE one cycle after the accepting cycle. A `start` issued during HOLD is ignored.
6. `auto_en`=1, PERIOD=50: consecutive CLEAR cycles are spaced by PERIOD + full window length. `reset` asserted at ACCUM cycle 40 → all outputs 0 immediately and no `done` pulse.
